// File: rtl/vec_strided_lsu_if.sv
// vec_strided_lsu_if: single-port word-memory request/response bus
//   mem_valid  request valid (master -> slave)
//   mem_ready  one-cycle response pulse (slave -> master)
//   mem_addr   word-aligned byte address
//   mem_wdata  lane-shifted store data
//   mem_wstrb  byte strobes, 0 for loads
//   mem_rdata  load data, valid with mem_ready
interface vec_strided_lsu_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
    modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/vec_strided_lsu.sv
// vec_strided_lsu: strided vector load/store engine driving a single-port word memory
//   clk, reset           clock, async active-high reset
//   start, is_store      launch pulse and direction (sampled on start)
//   base_addr, stride    element 0 byte address and signed byte stride
//   vl, sew              element count and element width (00=8b, 01=16b, 10=32b)
//   busy, done, err      operation in flight, completion pulse, sticky error
//   elem_we/widx/wdata   register-file element write (loads)
//   elem_ridx/rdata      register-file element read (stores)
//   mem                  memory bus master
module vec_strided_lsu #(
    parameter int IDX_W  = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [IDX_W-1:0]  vl,
    input  logic [1:0]        sew,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              elem_we,
    output logic [IDX_W-1:0]  elem_widx,
    output logic [31:0]       elem_wdata,
    output logic [IDX_W-1:0]  elem_ridx,
    input  logic [31:0]       elem_rdata,
    vec_strided_lsu_if.master mem
);
    typedef enum logic [2:0] {IDLE, CHK, RD, REQ, GAP, FIN} state_t;
    state_t state, nxt;
    logic              st;
    logic [ADDR_W-1:0] stride_r, cur;
    logic [IDX_W-1:0]  vl_r, k;
    logic [1:0]        sew_r;
    logic [31:0]       wdata_r, mask;
    logic [3:0]        wstrb_r, bmask;
    logic [4:0]        sh;
    logic              bad, ack;
    assign sh    = {cur[1:0], 3'b000};
    assign mask  = sew_r == 2'd0 ? 32'h0000_00ff : sew_r == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff;
    assign bmask = sew_r == 2'd0 ? 4'b0001 : sew_r == 2'd1 ? 4'b0011 : 4'b1111;
    // illegal width or an element that is not naturally aligned within its word
    assign bad   = sew_r == 2'd3 || (sew_r == 2'd1 && cur[0]) || (sew_r == 2'd2 && cur[1:0] != 2'd0);
    assign ack   = state == REQ && mem.mem_ready;
    assign busy  = state inside {CHK, RD, REQ, GAP};
    assign done  = state == FIN;
    assign elem_ridx     = k;
    assign mem.mem_valid = state == REQ;
    assign mem.mem_addr  = {cur[31:2], 2'b00};
    assign mem.mem_wdata = wdata_r;
    assign mem.mem_wstrb = wstrb_r;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = start ? CHK : IDLE;
            CHK:  nxt = (vl_r == '0 || bad) ? FIN : st ? RD : REQ;
            RD:   nxt = REQ;
            REQ:  nxt = mem.mem_ready ? GAP : REQ;
            GAP:  nxt = k == vl_r ? FIN : CHK;
            FIN:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            st         <= 1'b0;
            stride_r   <= '0;
            cur        <= '0;
            vl_r       <= '0;
            k          <= '0;
            sew_r      <= 2'd0;
            err        <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            elem_we    <= 1'b0;
            elem_widx  <= '0;
            elem_wdata <= '0;
        end else begin
            elem_we <= ack && !st;
            if (state == IDLE && start) begin
                st       <= is_store;
                stride_r <= stride;
                vl_r     <= vl;
                sew_r    <= sew;
                cur      <= base_addr;
                k        <= '0;
                err      <= 1'b0;
                wstrb_r  <= '0;
            end
            if (state == CHK && vl_r != '0 && bad)
                err <= 1'b1;
            if (state == RD) begin
                wdata_r <= (elem_rdata & mask) << sh;
                wstrb_r <= bmask << cur[1:0];
            end
            if (ack) begin
                k        <= k + 1'b1;
                cur      <= cur + stride_r;
                wstrb_r  <= '0;
                if (!st) begin
                    elem_widx  <= k;
                    elem_wdata <= (mem.mem_rdata >> sh) & mask;
                end
            end
        end
endmodule

// File: tb/tb_vec_strided_lsu.sv
// tb_vec_strided_lsu: scoreboard bench for vec_strided_lsu with a random-latency memory responder
module tb_vec_strided_lsu;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_store = 1'b0;
    logic [31:0] base_addr = '0, stride = '0;
    logic [4:0]  vl = '0;
    logic [1:0]  sew = '0;
    logic        busy, done, err, elem_we;
    logic [4:0]  elem_widx, elem_ridx;
    logic [31:0] elem_wdata, elem_rdata;
    vec_strided_lsu_if mem_bus();
    vec_strided_lsu dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .vl(vl), .sew(sew),
        .busy(busy), .done(done), .err(err), .elem_we(elem_we),
        .elem_widx(elem_widx), .elem_wdata(elem_wdata),
        .elem_ridx(elem_ridx), .elem_rdata(elem_rdata), .mem(mem_bus)
    );
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; bit st; } req_t;
    typedef struct { logic [4:0] idx; logic [31:0] data; } elem_t;
    req_t        req_q[$];
    elem_t       elem_q[$];
    bit          err_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] mem[256], ref_mem[256], regf[32], got_elem[32];
    int          total = 0, bad = 0;
    assign elem_rdata = regf[elem_ridx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: walk the elements by address arithmetic, stop at the first bad one.
    task automatic model(input bit st, input logic [31:0] b, input logic [31:0] s, input int n, input logic [1:0] sw);
        int          size;
        logic [31:0] msk, a;
        int          o;
        req_t        r;
        elem_t       e;
        bit          er;
        size = sw == 0 ? 1 : sw == 1 ? 2 : 4;
        msk  = sw == 0 ? 32'hff : sw == 1 ? 32'hffff : 32'hffff_ffff;
        er   = 0;
        for (int j = 0; j < n; j++) begin
            a = b + s * 32'(j);
            if (sw == 2'd3 || (a % size) != 0) begin
                er = 1;
                break;
            end
            o       = int'(a[1:0]);
            r.addr  = {a[31:2], 2'b00};
            r.st    = st;
            r.wstrb = st ? 4'(((1 << size) - 1) << o) : 4'b0000;
            r.wdata = st ? (regf[j] & msk) << (8 * o) : 32'h0;
            req_q.push_back(r);
            if (st) begin
                for (int bt = 0; bt < 4; bt++)
                    if (r.wstrb[bt]) ref_mem[a[9:2]][8*bt +: 8] = r.wdata[8*bt +: 8];
            end else begin
                e.idx  = 5'(j);
                e.data = (ref_mem[a[9:2]] >> (8 * o)) & msk;
                elem_q.push_back(e);
            end
        end
        err_q.push_back(er);
    endtask

    // Memory responder and request monitor
    initial begin
        int          dly;
        logic [7:0]  wi;
        req_t        r;
        dly = 0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_ready = 1'b0;
            if (mem_bus.mem_valid && !reset) begin
                if (dly == 0) begin
                    wi = mem_bus.mem_addr[9:2];
                    mem_bus.mem_rdata = mem[wi];
                    mem_bus.mem_ready = 1'b1;
                    addr_log.push_back(mem_bus.mem_addr);
                    for (int bt = 0; bt < 4; bt++)
                        if (mem_bus.mem_wstrb[bt]) mem[wi][8*bt +: 8] = mem_bus.mem_wdata[8*bt +: 8];
                    if (req_q.size() == 0)
                        chk("req_unexpected", 32'(req_q.size()), 32'd1);
                    else begin
                        r = req_q.pop_front();
                        chk("req_addr", mem_bus.mem_addr, r.addr);
                        chk("req_wstrb", {28'b0, mem_bus.mem_wstrb}, {28'b0, r.wstrb});
                        if (r.st) chk("req_wdata", mem_bus.mem_wdata, r.wdata);
                    end
                    dly = $urandom_range(0, 2);
                end else
                    dly--;
            end
        end
    end

    // Element write monitor
    initial begin
        elem_t e;
        forever begin
            @(posedge clk);
            #1;
            if (elem_we) begin
                if (elem_q.size() == 0)
                    chk("elem_unexpected", 32'(elem_q.size()), 32'd1);
                else begin
                    e = elem_q.pop_front();
                    chk("elem_idx", {27'b0, elem_widx}, {27'b0, e.idx});
                    chk("elem_data", elem_wdata, e.data);
                    got_elem[elem_widx] = elem_wdata;
                end
            end
        end
    end

    // Completion monitor
    initial begin
        bit ex;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (err_q.size() == 0)
                    chk("done_unexpected", 32'(err_q.size()), 32'd1);
                else begin
                    ex = err_q.pop_front();
                    chk("err", {31'b0, err}, {31'b0, ex});
                    chk("req_left", 32'(req_q.size()), 32'd0);
                    chk("elem_left", 32'(elem_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic run(input bit st, input logic [31:0] b, input logic [31:0] s, input int n,
                       input logic [1:0] sw, input bit poke, output int cyc);
        model(st, b, s, n, sw);
        addr_log.delete();
        is_store  = st;
        base_addr = b;
        stride    = s;
        vl        = 5'(n);
        sew       = sw;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("err_cleared", {31'b0, err}, 32'd0);
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) chk("fin_start_ignored", {31'b0, busy}, 32'd0);
    endtask

    task automatic mem_cmp;
        int diffs;
        diffs = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_match", 32'(diffs), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n;
        bit          st;
        logic [31:0] b, s;
        logic [1:0]  sw;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 28; i++)
            mem[100 + i] = {8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)};
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) begin
            regf[i] = $urandom;
            got_elem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_elem_we", {31'b0, elem_we}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_bus.mem_valid}, 32'd0);
        chk("rst_wstrb", {28'b0, mem_bus.mem_wstrb}, 32'd0);
        chk("rst_addr", mem_bus.mem_addr, 32'd0);
        chk("rst_wdata", mem_bus.mem_wdata, 32'd0);
        chk("rst_widx", {27'b0, elem_widx}, 32'd0);
        chk("rst_wdat", elem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run(0, 400, 4, 4, 2'd1, 0, cyc);
        chk("t1_e0", got_elem[0], 32'h0201);
        chk("t1_e1", got_elem[1], 32'h0605);
        chk("t1_e2", got_elem[2], 32'h0a09);
        chk("t1_e3", got_elem[3], 32'h0e0d);
        chk("t1_nreq", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) chk("t1_a3", addr_log[3], 32'd412);

        run(0, 400, 2, 4, 2'd1, 0, cyc);
        chk("t2_e1", got_elem[1], 32'h0403);
        chk("t2_e3", got_elem[3], 32'h0807);
        chk("t2_nreq", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("t2_a1", addr_log[1], 32'd400);
            chk("t2_a2", addr_log[2], 32'd404);
        end

        for (int i = 0; i < 4; i++) regf[i] = 32'hdead_be00 | 32'(8'hA0 + i);
        run(1, 440, 1, 4, 2'd0, 0, cyc);
        chk("t3_w110", mem[110], 32'hA3A2A1A0);
        chk("t3_w109", mem[109], 32'h28272625);
        chk("t3_w111", mem[111], 32'h302f2e2d);
        mem_cmp();

        run(0, 402, 4, 3, 2'd2, 0, cyc);
        chk("mis_latency", 32'(cyc), 32'd2);
        chk("mis_nreq", 32'(addr_log.size()), 32'd0);
        chk("err_sticky", {31'b0, err}, 32'd1);
        run(0, 400, 4, 2, 2'd2, 0, cyc);

        run(1, 400, 4, 0, 2'd2, 1, cyc);
        chk("vl0_latency", 32'(cyc), 32'd2);
        chk("vl0_nreq", 32'(addr_log.size()), 32'd0);
        run(0, 412, 32'hffff_fffc, 4, 2'd2, 0, cyc);
        chk("neg_nreq", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("neg_a0", addr_log[0], 32'd412);
            chk("neg_a3", addr_log[3], 32'd400);
        end

        model(0, 400, 4, 4, 2'd2);
        is_store = 0; base_addr = 400; stride = 4; vl = 5'd4; sew = 2'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!(mem_bus.mem_valid && mem_bus.mem_addr == 32'd408) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rst_saw_req2", {31'b0, mem_bus.mem_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_valid", {31'b0, mem_bus.mem_valid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_we", {31'b0, elem_we}, 32'd0);
        req_q.delete();
        elem_q.delete();
        err_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {31'b0, done}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(0, 400, 4, 4, 2'd2, 0, cyc);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 32; i++) regf[i] = $urandom;
            st = 1'($urandom_range(0, 1));
            sw = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            b  = 32'd400 + 32'(4 * $urandom_range(0, 50));
            if ($urandom_range(0, 3) == 0) b = b + 32'($urandom_range(1, 3));
            s  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 16)) - 32'd8
                                           : 32'(4 * $urandom_range(0, 8)) - 32'd16;
            n  = $urandom_range(0, 8);
            run(st, b, s, n, sw, 0, cyc);
            mem_cmp();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_strided_lsu.md
Name: vec_strided_lsu

Overview:
- Initiator side of the vector coprocessor memory interface: executes one strided vector load (vlse) or store (vsse) of vl elements.
- Element k is at address base + k*stride, with SEW of 8, 16 or 32 bits.
- Drives the single-port mem_valid/mem_ready word-memory protocol; load data is written into the vector register file one element per access.
- Sits between the pcpi_vec decode/control FSM (start/done) and the shared memory port.

Parameters:
- IDX_W, 5, width of element index and vl; max vl = 2**IDX_W - 1.
- ADDR_W, 32, memory byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches an operation; ignored while busy=1.
- is_store  in  1  sampled on start: 1 = strided store, 0 = strided load.
- base_addr  in  ADDR_W  sampled on start: byte address of element 0.
- stride  in  ADDR_W  sampled on start: byte stride, two's complement; 0 and negative are legal.
- vl  in  IDX_W  sampled on start: element count.
- sew  in  2  sampled on start: 00=8b, 01=16b, 10=32b, 11=illegal.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion, including on error.
- err  out  1  sticky misalign/illegal-SEW flag; cleared by the next accepted start.
- elem_we  out  1  load: register-file element write strobe.
- elem_widx  out  IDX_W  load: element index being written.
- elem_wdata  out  32  load: zero-extended element value.
- elem_ridx  out  IDX_W  store: element index to read.
- elem_rdata  in  32  store: combinational register-file read of elem_ridx; low SEW bits used.
- mem_valid  out  1  request valid.
- mem_ready  in  1  one-cycle response pulse.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  store data, lane-shifted.
- mem_wstrb  out  4  byte strobes; 0 for loads.
- mem_rdata  in  32  load data, valid when mem_ready=1.

Behaviour:
- Reset: state IDLE. busy, done, err, elem_we and mem_valid are 0. mem_wstrb is 0. All address, data and index outputs are 0. Reset mid-operation aborts immediately with no done pulse; the memory word may or may not have been written.
- FSM states are IDLE, CHK, RD, REQ, GAP, FIN.
- IDLE: start latches the operands, clears err, sets k=0 and cur=base_addr, then goes to CHK.
- CHK:
  - If vl=0, go to FIN.
  - If sew=11, or cur is misaligned (16b with cur[0]=1, 32b with cur[1:0]!=0), set err and go to FIN.
  - Otherwise go to RD for a store, REQ for a load.
- RD (store only, 1 cycle):
  - elem_ridx=k.
  - At the clock edge, latch mem_wdata = elem_rdata masked to SEW, shifted left by 8*cur[1:0].
  - At the same edge, latch mem_wstrb = SEW mask (0001/0011/1111) shifted left by cur[1:0].
  - Go to REQ.
- REQ:
  - mem_valid=1, with mem_addr, mem_wdata and mem_wstrb held stable until mem_ready is sampled 1.
  - Load on ready: elem_we pulses in the following cycle with elem_widx=k and elem_wdata = (mem_rdata >> 8*cur[1:0]) masked to SEW, zero-extended.
  - On ready, mem_valid drops at that same edge. Then k=k+1 and cur = cur + stride (mod 2^32), and the FSM goes to GAP.
- GAP: mem_valid=0 for exactly one cycle. Go to FIN if k==vl, else to CHK.
- Each element is re-checked for alignment in CHK. A misalignment at k>0 aborts after k completed elements; earlier elements remain written.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE. Elements never span words.
- Latency with a responder that asserts mem_ready one cycle after seeing valid:
  - Load: 5 cycles per element.
  - Store: 6 cycles per element.
  - vl=0: done 2 cycles after start.
- Simultaneous start and done: start in the FIN cycle is ignored. start is accepted only in IDLE.

Test Plan:
- Load, word 100 = 0x04030201, word 101 = 0x08070605, base=400, stride=4, sew=01, vl=4 → elem_wdata 0x0201, 0x0605, then words 102/103 low halves (0x0a09, 0x0e0d). Exactly 4 mem requests at addresses 400, 404, 408, 412; done=1, err=0.
- Load, base=400, stride=2, sew=01, vl=4 → elem_wdata 0x0201, 0x0403, 0x0605, 0x0807. mem_addr sequence 400, 400, 404, 404.
- Store, sew=00, base=440, stride=1, vl=4, elem_rdata k → 0xA0+k → byte writes to word 110. mem_wstrb 0001, 0010, 0100, 1000. Final word 110 = 0xA3A2A1A0; neighbouring bytes untouched.
- Misalign, sew=10, base=402, vl=3 → no mem_valid, err=1, done one cycle later. Next start with base=400 clears err.
- vl=0 → no memory traffic, done 2 cycles after start. Negative stride -4 from base 412, sew=10, vl=4 → addresses 412, 408, 404, 400.
- Assert reset during REQ of element 2 → mem_valid, busy and elem_we are 0 immediately, no done. A subsequent start completes normally.
